// File: rtl/shift_counter_seq_pkg.sv
// Shared definitions for the ring/Johnson shift counter sequencer.
//   MODE_*    : run mode encoding as seen on the request bus
//   state_e   : sequencer FSM encoding
//   seed_lsb  : seed value's LSB for a mode (all other seed bits are zero)
package shift_counter_seq_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ring seeds a single one-hot bit, Johnson seeds all zeros; both seeds are
  // zero above bit 0, so only the LSB depends on mode.
  function automatic logic seed_lsb(input logic mode);
    return (mode == MODE_RING);
  endfunction

endpackage

// File: rtl/shift_counter_seq_if.sv
// Request/status bus between host control and the shift counter sequencer.
//   master : host side (drives start/mode/n_steps/en/stop)
//   slave  : sequencer side (drives ready/busy/q/step_cnt/wrap/done/aborted)
interface shift_counter_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] n_steps;
  logic             en;
  logic             stop;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] step_cnt;
  logic             wrap;
  logic             done;
  logic             aborted;

  modport master (
    output start, mode, n_steps, en, stop,
    input  ready, busy, q, step_cnt, wrap, done, aborted
  );

  modport slave (
    input  start, mode, n_steps, en, stop,
    output ready, busy, q, step_cnt, wrap, done, aborted
  );
endinterface

// File: rtl/shift_counter_seq_shift_core.sv
// Shift-register datapath: ring or Johnson rotation with synchronous seed load.
//   clk, rst   : clock, async active-high reset (q clears to 0)
//   mode_i     : 0 ring, 1 Johnson
//   load_i     : load seed_i (priority over shift_i)
//   seed_i     : seed value
//   shift_i    : advance one step
//   q_o        : current value
//   q_shift_o  : value the register would take on a shift (for wrap detect)
module shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             shift_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_shift_o
);
  import shift_counter_seq_pkg::*;

  logic [WIDTH-1:0] q_q;

  // Johnson feeds back the inverted MSB; ring feeds it back as-is.
  assign q_shift_o = {q_q[WIDTH-2:0], (mode_i == MODE_JOHNSON) ? ~q_q[WIDTH-1] : q_q[WIDTH-1]};
  assign q_o       = q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q_q <= '0;
    else if (load_i)  q_q <= seed_i;
    else if (shift_i) q_q <= q_shift_o;
  end

endmodule

// File: rtl/shift_counter_seq.sv
// Sequencer for the ring/Johnson shift counter.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of shift_counter_seq_if
//              in : start, mode, n_steps, en, stop
//              out: ready, busy, q, step_cnt, wrap, done, aborted
// A run is accepted in IDLE, seeds the core, shifts on en cycles until
// n_steps shifts are done or stop arrives, then spends one cycle in DONE.
module shift_counter_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_counter_seq_if.slave   bus
);
  import shift_counter_seq_pkg::*;

  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] n_steps_q;
  logic [CNT_W-1:0] step_cnt_q;
  logic             wrap_q;
  logic             done_q;
  logic             aborted_q;

  logic             accept;
  logic             do_shift;
  logic             core_mode;
  logic [WIDTH-1:0] load_seed;
  logic [WIDTH-1:0] run_seed;
  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] q_shift;
  logic [CNT_W-1:0] cnt_inc;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  // stop wins over en: no shift in the abort cycle.
  assign do_shift  = (state_q == ST_RUN) && bus.en && !bus.stop;
  // On accept the core must already see the new mode; afterwards the latched one.
  assign core_mode = accept ? bus.mode : mode_q;
  assign load_seed = {{(WIDTH-1){1'b0}}, seed_lsb(bus.mode)};
  assign run_seed  = {{(WIDTH-1){1'b0}}, seed_lsb(mode_q)};
  assign cnt_inc   = step_cnt_q + 1'b1;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .mode_i    (core_mode),
    .load_i    (accept),
    .seed_i    (load_seed),
    .shift_i   (do_shift),
    .q_o       (q_cur),
    .q_shift_o (q_shift)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RING;
      n_steps_q  <= '0;
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q     <= bus.mode;
            n_steps_q  <= bus.n_steps;
            step_cnt_q <= '0;
            aborted_q  <= 1'b0;
            if (bus.n_steps == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            aborted_q <= 1'b1;
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
          end else if (bus.en) begin
            step_cnt_q <= cnt_inc;
            wrap_q     <= (q_shift == run_seed);
            if (cnt_inc == n_steps_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.q        = q_cur;
  assign bus.step_cnt = step_cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_shift_counter_seq.sv
// Directed bench for shift_counter_seq: ring/Johnson runs, en gaps, stop,
// ignored start/mode changes, zero-step run and off-edge reset.
module tb_shift_counter_seq;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   errs;
  int   nchk;

  shift_counter_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_counter_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ring_e [0:8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] john_e [0:15] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [6:0] en_pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic m, input logic [CNT_W-1:0] n);
    bus.start = 1'b1; bus.mode = m; bus.n_steps = n;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    errs = 0; nchk = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.n_steps = '0; bus.en = 1'b0; bus.stop = 1'b0;
    #12;
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_q", bus.q, 0);
    chk("rst_cnt", bus.step_cnt, 0);
    chk("rst_flags", {bus.wrap, bus.done, bus.aborted}, 0);
    rst = 1'b0;
    tick();

    // 1: ring, 9 steps
    bus.en = 1'b1;
    accept(1'b0, 8'd9);
    chk("t1_seed", bus.q, 8'h01);
    chk("t1_busy", bus.busy, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t1_q%0d", i + 1), bus.q, ring_e[i]);
      chk($sformatf("t1_wrap%0d", i + 1), bus.wrap, (i == 7));
      chk($sformatf("t1_done%0d", i + 1), bus.done, (i == 8));
    end
    chk("t1_cnt", bus.step_cnt, 9);
    tick();
    chk("t1_idle", bus.ready, 1);
    chk("t1_hold_q", bus.q, 8'h02);
    chk("t1_hold_cnt", bus.step_cnt, 9);

    // 2: Johnson, 16 steps
    accept(1'b1, 8'd16);
    chk("t2_seed", bus.q, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t2_q%0d", i + 1), bus.q, john_e[i]);
      chk($sformatf("t2_wrap%0d", i + 1), bus.wrap, (i == 15));
      chk($sformatf("t2_done%0d", i + 1), bus.done, (i == 15));
    end
    tick();

    // 3: ring, 4 steps with en gaps
    bus.en = 1'b0;
    accept(1'b0, 8'd4);
    for (int i = 0; i < 7; i++) begin
      bus.en = en_pat[i];
      tick();
      if (i == 3) chk("t3_mid_cnt", bus.step_cnt, 2);
    end
    bus.en = 1'b0;
    chk("t3_q", bus.q, 8'h10);
    chk("t3_cnt", bus.step_cnt, 4);
    chk("t3_done", bus.done, 1);
    tick();
    chk("t3_idle_q", bus.q, 8'h10);

    // 4: stop after 3 shifts, asserted together with en
    bus.en = 1'b1;
    accept(1'b0, 8'd10);
    tick(); tick(); tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t4_q", bus.q, 8'h08);
    chk("t4_cnt", bus.step_cnt, 3);
    chk("t4_aborted", bus.aborted, 1);
    chk("t4_done", bus.done, 1);
    chk("t4_busy", bus.busy, 0);
    tick();
    chk("t4_idle", bus.ready, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t4_stop_idle", {bus.ready, bus.aborted, bus.done}, 3'b110);

    // 5: start/mode/n_steps changes during RUN are ignored
    accept(1'b0, 8'd5);
    chk("t5_abort_clr", bus.aborted, 0);
    bus.start = 1'b1; bus.mode = 1'b1; bus.n_steps = 8'd2;
    tick(); tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("t5_q", bus.q, 8'h20);
    chk("t5_cnt", bus.step_cnt, 5);
    chk("t5_done", bus.done, 1);
    tick();
    chk("t5_idle", bus.ready, 1);
    accept(1'b0, 8'd0);
    chk("t5_zero_q", bus.q, 8'h01);
    chk("t5_zero_done", bus.done, 1);
    chk("t5_zero_cnt", bus.step_cnt, 0);
    chk("t5_zero_busy", bus.busy, 0);
    tick();
    chk("t5_zero_idle", {bus.ready, bus.done}, 2'b10);

    // 6: off-edge reset in RUN, then clean run
    accept(1'b1, 8'd20);
    tick(); tick(); tick(); tick(); tick();
    chk("t6_pre_q", bus.q, 8'h1F);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_q", bus.q, 0);
    chk("t6_rst_cnt", bus.step_cnt, 0);
    chk("t6_rst_state", {bus.ready, bus.busy, bus.done, bus.wrap, bus.aborted}, 5'b10000);
    #1 rst = 1'b0;
    tick();
    accept(1'b0, 8'd3);
    tick(); tick(); tick();
    chk("t6_q", bus.q, 8'h08);
    chk("t6_done", bus.done, 1);
    bus.en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
